// File: rtl/gemac_tx_frame_arbiter.sv
// gemac_tx_frame_arbiter: frame-atomic 2:1 fifo36 arbiter feeding the GEMAC tx_f36 input.
// Define GEMAC_TX_ARB_STRICT_PRIO_EN for fixed port-0 priority instead of round-robin.
module gemac_tx_frame_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [1:0]  en,
    input  logic [35:0] in0_data,
    input  logic        in0_src_rdy,
    output logic        in0_dst_rdy,
    input  logic [35:0] in1_data,
    input  logic        in1_src_rdy,
    output logic        in1_dst_rdy,
    output logic [35:0] out_data,
    output logic        out_src_rdy,
    input  logic        out_dst_rdy,
    output logic [1:0]  grant,
    output logic [15:0] frames0,
    output logic [15:0] frames1,
    output logic [15:0] orphans
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS0 = 2'b01,
        PASS1 = 2'b10
    } state_t;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [15:0] frames0_q;
    logic [15:0] frames1_q;
    logic [15:0] orphans_q;
`ifndef GEMAC_TX_ARB_STRICT_PRIO_EN
    logic        last_q;
`endif

    logic        cand0;
    logic        cand1;
    logic        orph0;
    logic        orph1;
    logic        pick0;
    logic        pick1;
    logic        done0;
    logic        done1;
    logic [16:0] orph_sum;
    logic [15:0] orphans_d;

    assign cand0 = en[0] & in0_src_rdy & in0_data[32];
    assign cand1 = en[1] & in1_src_rdy & in1_data[32];
    assign orph0 = en[0] & in0_src_rdy & ~in0_data[32];
    assign orph1 = en[1] & in1_src_rdy & ~in1_data[32];

`ifdef GEMAC_TX_ARB_STRICT_PRIO_EN
    assign pick0 = cand0;
`else
    // On a tie the port that did not win last time goes first.
    assign pick0 = cand0 & (~cand1 | last_q);
`endif
    assign pick1 = cand1 & ~pick0;

    assign done0 = (state_q == PASS0) & in0_src_rdy
                 & out_dst_rdy & in0_data[33];
    assign done1 = (state_q == PASS1) & in1_src_rdy
                 & out_dst_rdy & in1_data[33];

    assign orph_sum  = {1'b0, orphans_q}
                     + {16'b0, orph0}
                     + {16'b0, orph1};
    assign orphans_d = orph_sum[16] ? 16'hFFFF : orph_sum[15:0];

    always_comb begin
        out_data    = '0;
        out_src_rdy = 1'b0;
        in0_dst_rdy = 1'b0;
        in1_dst_rdy = 1'b0;
        unique case (state_q)
            IDLE: begin
                in0_dst_rdy = orph0;
                in1_dst_rdy = orph1;
            end
            PASS0: begin
                out_data    = in0_data;
                out_src_rdy = in0_src_rdy;
                in0_dst_rdy = out_dst_rdy;
            end
            PASS1: begin
                out_data    = in1_data;
                out_src_rdy = in1_src_rdy;
                in1_dst_rdy = out_dst_rdy;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset | clear) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            frames0_q <= '0;
            frames1_q <= '0;
            orphans_q <= '0;
`ifndef GEMAC_TX_ARB_STRICT_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    orphans_q <= orphans_d;
                    if (pick0) begin
                        state_q <= PASS0;
                        grant_q <= 2'b01;
`ifndef GEMAC_TX_ARB_STRICT_PRIO_EN
                        last_q  <= 1'b0;
`endif
                    end else if (pick1) begin
                        state_q <= PASS1;
                        grant_q <= 2'b10;
`ifndef GEMAC_TX_ARB_STRICT_PRIO_EN
                        last_q  <= 1'b1;
`endif
                    end
                end
                PASS0: begin
                    if (done0) begin
                        state_q   <= IDLE;
                        grant_q   <= 2'b00;
                        frames0_q <= frames0_q + 16'd1;
                    end
                end
                PASS1: begin
                    if (done1) begin
                        state_q   <= IDLE;
                        grant_q   <= 2'b00;
                        frames1_q <= frames1_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign frames0 = frames0_q;
    assign frames1 = frames1_q;
    assign orphans = orphans_q;

endmodule

// File: tb/tb_gemac_tx_frame_arbiter.sv
// tb_gemac_tx_frame_arbiter: randomized and directed bench for the tx frame arbiter,
// scored against a transaction-level model of per-port frame queues.
module tb_gemac_tx_frame_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [1:0]  en;
    logic [35:0] in0_data;
    logic        in0_src_rdy;
    logic        in0_dst_rdy;
    logic [35:0] in1_data;
    logic        in1_src_rdy;
    logic        in1_dst_rdy;
    logic [35:0] out_data;
    logic        out_src_rdy;
    logic        out_dst_rdy;
    logic [1:0]  grant;
    logic [15:0] frames0;
    logic [15:0] frames1;
    logic [15:0] orphans;

    always #5 clk = ~clk;

    gemac_tx_frame_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .en          (en),
        .in0_data    (in0_data),
        .in0_src_rdy (in0_src_rdy),
        .in0_dst_rdy (in0_dst_rdy),
        .in1_data    (in1_data),
        .in1_src_rdy (in1_src_rdy),
        .in1_dst_rdy (in1_dst_rdy),
        .out_data    (out_data),
        .out_src_rdy (out_src_rdy),
        .out_dst_rdy (out_dst_rdy),
        .grant       (grant),
        .frames0     (frames0),
        .frames1     (frames1),
        .orphans     (orphans)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [35:0] q0[$];
    logic [35:0] q1[$];
    logic [35:0] e0[$];
    logic [35:0] e1[$];
    int          order[$];
    int          sb_port;
    int          exp_f0;
    int          exp_f1;
    int          exp_orph;
    int          src_mode;
    int          dst_mode;
    int          pat_i;

    logic [1:0]  s_g;
    logic        s_osr;
    logic        s_ods;
    logic        s_hs0;
    logic        s_hs1;
    logic        s_d1;
    logic [35:0] s_od;

    task automatic push_frame(input int p, input int n);
        logic [35:0] w;
        for (int i = 0; i < n; i++) begin
            w[31:0]  = $urandom;
            w[32]    = (i == 0);
            w[33]    = (i == n - 1);
            w[35:34] = 2'($urandom_range(0, 3));
            if (p == 0) begin
                q0.push_back(w);
                e0.push_back(w);
            end else begin
                q1.push_back(w);
                e1.push_back(w);
            end
        end
        if (p == 0) exp_f0++;
        else        exp_f1++;
    endtask

    task automatic push_orphans(input int p, input int n);
        logic [35:0] w;
        for (int i = 0; i < n; i++) begin
            w[31:0]  = $urandom;
            w[32]    = 1'b0;
            w[33]    = 1'($urandom_range(0, 1));
            w[35:34] = 2'($urandom_range(0, 3));
            if (p == 0) q0.push_back(w);
            else        q1.push_back(w);
        end
        exp_orph = (exp_orph + n > 65535) ? 65535 : exp_orph + n;
    endtask

    task automatic drive();
        in0_src_rdy = (q0.size() > 0)
                    && (src_mode == 0 || $urandom_range(0, 3) != 0);
        in1_src_rdy = (q1.size() > 0)
                    && (src_mode == 0 || $urandom_range(0, 3) != 0);
        in0_data = (q0.size() > 0) ? q0[0] : 36'h0;
        in1_data = (q1.size() > 0) ? q1[0] : 36'h0;
        case (dst_mode)
            0:       out_dst_rdy = 1'b1;
            1:       out_dst_rdy = 1'($urandom_range(0, 1));
            default: out_dst_rdy = (pat_i % 4 == 0) || (pat_i % 4 == 3);
        endcase
        pat_i++;
    endtask

    // One clock: drive, sample at negedge, score, then retire handshakes.
    task automatic cycle();
        int          p;
        logic [35:0] ex;
        logic        ok;
        drive();
        @(negedge clk);
        s_g   = grant;
        s_osr = out_src_rdy;
        s_ods = out_dst_rdy;
        s_od  = out_data;
        s_hs0 = in0_src_rdy & in0_dst_rdy;
        s_hs1 = in1_src_rdy & in1_dst_rdy;
        s_d1  = in1_dst_rdy;
        if (s_osr && s_ods) begin
            p = sb_port;
            if (p < 0) begin
                if (e0.size() > 0 && s_od === e0[0]) p = 0;
                else if (e1.size() > 0 && s_od === e1[0]) p = 1;
            end
            ok = 1'b0;
            ex = '0;
            if (p == 0 && e0.size() > 0) begin
                ex = e0[0];
                ok = s_hs0 && !s_hs1 && s_g == 2'b01;
            end else if (p == 1 && e1.size() > 0) begin
                ex = e1[0];
                ok = s_hs1 && !s_hs0 && s_g == 2'b10;
            end
            n_checks++;
            if (!ok || s_od !== ex)
                $display("FAIL xfer: got %h grant %b hs %b%b, want %h port %0d",
                         s_od, s_g, s_hs1, s_hs0, ex, p);
            else
                n_pass++;
            if (p == 0 && e0.size() > 0) begin
                if (sb_port < 0) order.push_back(0);
                sb_port = e0[0][33] ? -1 : 0;
                void'(e0.pop_front());
            end else if (p == 1 && e1.size() > 0) begin
                if (sb_port < 0) order.push_back(1);
                sb_port = e1[0][33] ? -1 : 1;
                void'(e1.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (s_hs0 && q0.size() > 0) void'(q0.pop_front());
        if (s_hs1 && q1.size() > 0) void'(q1.pop_front());
    endtask

    task automatic apply_reset();
        q0.delete();
        q1.delete();
        e0.delete();
        e1.delete();
        order.delete();
        sb_port  = -1;
        exp_f0   = 0;
        exp_f1   = 0;
        exp_orph = 0;
        src_mode = 0;
        dst_mode = 0;
        pat_i    = 0;
        reset    = 1'b1;
        cycle();
        reset    = 1'b0;
    endtask

    task automatic run_until_empty(input int bound, input string tag);
        int k;
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb_port >= 0) && k < bound) begin
            cycle();
            k++;
        end
        n_checks++;
        if (k >= bound)
            $display("FAIL %s timeout: q0 %0d q1 %0d left, want 0", tag, q0.size(), q1.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        en = 2'b11;
        apply_reset();
        n_checks++;
        if (grant !== 2'b00 || out_src_rdy !== 1'b0)
            $display("FAIL reset_hs: grant %b osr %b, want 00 0", grant, out_src_rdy);
        else n_pass++;
        n_checks++;
        if (frames0 !== 16'd0 || frames1 !== 16'd0 || orphans !== 16'd0)
            $display("FAIL reset_cnt: %0d %0d %0d, want 0 0 0", frames0, frames1, orphans);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        apply_reset();
        en = 2'b11;
        push_frame(0, 4);
        cycle();
        n_checks++;
        if (s_g !== 2'b00 || s_osr !== 1'b0 || s_hs0 !== 1'b0)
            $display("FAIL bubble: grant %b osr %b hs %b, want 00 0 0", s_g, s_osr, s_hs0);
        else n_pass++;
        repeat (4) cycle();
        n_checks++;
        if (e0.size() != 0)
            $display("FAIL single_words: %0d left, want 0", e0.size());
        else n_pass++;
        cycle();
        n_checks++;
        if (s_g !== 2'b00 || frames0 !== 16'(exp_f0))
            $display("FAIL single_end: grant %b frames0 %0d, want 00 %0d", s_g, frames0, exp_f0);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int want;
        int got;
        apply_reset();
        en = 2'b11;
        for (int i = 0; i < 4; i++) begin
            push_frame(0, 3);
            push_frame(1, 3);
        end
        run_until_empty(200, "rr");
        for (int i = 0; i < 8; i++) begin
`ifdef GEMAC_TX_ARB_STRICT_PRIO_EN
            want = (i < 4) ? 0 : 1;
`else
            want = i % 2;
`endif
            got = (i < order.size()) ? order[i] : -1;
            n_checks++;
            if (got != want)
                $display("FAIL rr_order[%0d]: port %0d, want %0d", i, got, want);
            else n_pass++;
        end
        n_checks++;
        if (frames0 !== 16'(exp_f0) || frames1 !== 16'(exp_f1))
            $display("FAIL rr_frames: %0d %0d, want %0d %0d", frames0, frames1, exp_f0, exp_f1);
        else n_pass++;
    endtask

    task automatic test_orphans();
        logic saw;
        apply_reset();
        en = 2'b11;
        push_orphans(1, 5);
        saw = 1'b0;
        repeat (8) begin
            cycle();
            saw |= s_osr;
        end
        n_checks++;
        if (q1.size() != 0 || saw !== 1'b0)
            $display("FAIL orphan_drain: left %0d osr %b, want 0 0", q1.size(), saw);
        else n_pass++;
        n_checks++;
        if (orphans !== 16'(exp_orph))
            $display("FAIL orphan_cnt: %0d, want %0d", orphans, exp_orph);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic bad1;
        int   k;
        apply_reset();
        en = 2'b11;
        dst_mode = 2;
        push_frame(0, 6);
        bad1 = 1'b0;
        k = 0;
        while (e0.size() > 0 && k < 40) begin
            cycle();
            bad1 |= s_d1;
            k++;
        end
        cycle();
        n_checks++;
        if (e0.size() != 0 || q0.size() != 0 || bad1 !== 1'b0)
            $display("FAIL stall: left %0d/%0d in1_dst %b, want 0/0 0", e0.size(), q0.size(), bad1);
        else n_pass++;
        n_checks++;
        if (frames0 !== 16'(exp_f0))
            $display("FAIL stall_frames: %0d, want %0d", frames0, exp_f0);
        else n_pass++;
        dst_mode = 0;
    endtask

    task automatic test_enable();
        logic saw;
        int   k;
        apply_reset();
        en = 2'b01;
        push_frame(1, 3);
        saw = 1'b0;
        repeat (10) begin
            cycle();
            saw |= (s_g == 2'b10);
        end
        n_checks++;
        if (saw !== 1'b0 || q1.size() != 3)
            $display("FAIL en_block: granted %b left %0d, want 0 3", saw, q1.size());
        else n_pass++;
        push_frame(0, 5);
        k = 0;
        while (e0.size() > 3 && k < 20) begin
            cycle();
            k++;
        end
        en = 2'b00;
        k = 0;
        while (e0.size() > 0 && k < 20) begin
            cycle();
            k++;
        end
        cycle();
        n_checks++;
        if (frames0 !== 16'd1 || e0.size() != 0)
            $display("FAIL en_midframe: frames0 %0d left %0d, want 1 0", frames0, e0.size());
        else n_pass++;
        n_checks++;
        if (grant !== 2'b00 || q1.size() != 3)
            $display("FAIL en_off: grant %b left %0d, want 00 3", grant, q1.size());
        else n_pass++;
    endtask

    task automatic test_clear();
        int k;
        apply_reset();
        en = 2'b11;
        push_orphans(0, 2);
        push_frame(1, 2);
        push_frame(0, 6);
        k = 0;
        while (e0.size() > 4 && k < 50) begin
            cycle();
            k++;
        end
        n_checks++;
        if (frames1 !== 16'd1 || orphans !== 16'd2)
            $display("FAIL pre_clear: frames1 %0d orphans %0d, want 1 2", frames1, orphans);
        else n_pass++;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        n_checks++;
        if (grant !== 2'b00 || out_src_rdy !== 1'b0)
            $display("FAIL clear_state: grant %b osr %b, want 00 0", grant, out_src_rdy);
        else n_pass++;
        n_checks++;
        if (frames0 !== 16'd0 || frames1 !== 16'd0 || orphans !== 16'd0)
            $display("FAIL clear_cnt: %0d %0d %0d, want 0 0 0", frames0, frames1, orphans);
        else n_pass++;
    endtask

    task automatic test_orphan_saturate();
        apply_reset();
        en = 2'b11;
        push_orphans(0, 33000);
        push_orphans(1, 33000);
        run_until_empty(34000, "sat");
        n_checks++;
        if (orphans !== 16'(exp_orph))
            $display("FAIL orphan_sat: %0d, want %0d", orphans, exp_orph);
        else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        en = 2'b11;
        src_mode = 1;
        dst_mode = 1;
        for (int it = 0; it < 30; it++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 9) < 8)
                    push_frame(p, int'($urandom_range(1, 6)));
                else
                    push_orphans(p, int'($urandom_range(1, 3)));
            end
        end
        run_until_empty(5000, "rand");
        cycle();
        n_checks++;
        if (frames0 !== 16'(exp_f0) || frames1 !== 16'(exp_f1))
            $display("FAIL rand_frames: %0d %0d, want %0d %0d", frames0, frames1, exp_f0, exp_f1);
        else n_pass++;
        n_checks++;
        if (orphans !== 16'(exp_orph) || e0.size() != 0 || e1.size() != 0)
            $display("FAIL rand_orph: %0d left %0d/%0d, want %0d 0/0",
                     orphans, e0.size(), e1.size(), exp_orph);
        else n_pass++;
    endtask

    initial begin
        reset       = 1'b1;
        clear       = 1'b0;
        en          = 2'b11;
        in0_data    = '0;
        in1_data    = '0;
        in0_src_rdy = 1'b0;
        in1_src_rdy = 1'b0;
        out_dst_rdy = 1'b1;
        sb_port     = -1;
        exp_f0      = 0;
        exp_f1      = 0;
        exp_orph    = 0;
        src_mode    = 0;
        dst_mode    = 0;
        pat_i       = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_orphans();
        test_stall();
        test_enable();
        test_clear();
        test_random();
        test_orphan_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
